// File: rtl/calc_disp_pkg.sv
// Shared types, constants and the digit-to-segment decoder for the calculator display driver.
package calc_disp_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } disp_state_t;

  localparam int         NUM_POS   = 6;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles never occur but decode to blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 15-bit double-dabble converter: one shift per cycle, restartable by a new start.
module bin2bcd_seq
  import calc_disp_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [14:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  disp_state_t state;
  logic [14:0] bin_sr;
  logic [19:0] bcd_sr;
  logic [19:0] adj;
  logic [19:0] shifted;
  logic [3:0]  count;

  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < 5; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
    shifted = {adj[18:0], bin_sr[14]};
  end

  // done marks the cycle whose shift is the 15th, so the caller can commit bcd on that edge.
  assign busy = (state == CONVERT);
  assign done = busy && (count == 4'd14) && !start;
  assign bcd  = shifted;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      count  <= '0;
    end else if (start) begin
      state  <= CONVERT;
      bin_sr <= bin;
      bcd_sr <= '0;
      count  <= '0;
    end else if (state == CONVERT) begin
      bcd_sr <= shifted;
      bin_sr <= {bin_sr[13:0], 1'b0};
      count  <= count + 4'd1;
      if (count == 4'd14)
        state <= IDLE;
    end
  end

endmodule

// File: rtl/calc_display_driver.sv
// Captures controller results, converts them to BCD and scans a six-position seven-segment display.
// Define CALC_LEADING_ZERO_BLANK_EN to blank leading zero digits on positions 4..1.
module calc_display_driver
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] display_output,
  input  logic        complete,
  output logic        busy,
  output logic [19:0] bcd_out,
  output logic        bcd_neg,
  output logic        bcd_valid,
  output logic [6:0]  seg_n,
  output logic [5:0]  an_n
);

  localparam int            RW           = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [2:0]    LAST_POS     = 3'(NUM_POS - 1);

  logic          complete_q;
  logic          load;
  logic          sign_pend;
  logic          conv_done;
  logic [19:0]   conv_bcd;
  logic [RW-1:0] refresh_cnt;
  logic [2:0]    pos;
  logic [5:0]    lead_zero;
  logic [19:0]   digit_shift;
  logic [6:0]    seg_next;

  assign load = complete & ~complete_q;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .nRST  (nRST),
    .start (load),
    .bin   (display_output[14:0]),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // The sign is held beside the converter so a restart replaces it together with the magnitude.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      complete_q <= 1'b0;
      sign_pend  <= 1'b0;
      bcd_out    <= '0;
      bcd_neg    <= 1'b0;
      bcd_valid  <= 1'b0;
    end else begin
      complete_q <= complete;
      if (load)
        sign_pend <= display_output[15];
      if (conv_done) begin
        bcd_out   <= conv_bcd;
        bcd_neg   <= sign_pend && (conv_bcd != 20'd0);
        bcd_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    lead_zero = '0;
`ifdef CALC_LEADING_ZERO_BLANK_EN
    lead_zero[5] = 1'b1;
    for (int k = 4; k >= 1; k--)
      lead_zero[k] = lead_zero[k+1] && (bcd_out[k*4 +: 4] == 4'd0);
`endif
  end

  always_comb begin
    seg_next    = SEG_BLANK;
    digit_shift = bcd_out >> {pos, 2'b00};
    if (bcd_valid) begin
      if (pos == LAST_POS)
        seg_next = bcd_neg ? SEG_MINUS : SEG_BLANK;
      else if (!lead_zero[pos])
        seg_next = bcd_to_seg(digit_shift[3:0]);
    end
  end

  // seg_n and an_n are registered from the same index so they always switch together.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      refresh_cnt <= '0;
      pos         <= '0;
      seg_n       <= SEG_BLANK;
      an_n        <= 6'h3F;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        pos         <= (pos == LAST_POS) ? 3'd0 : pos + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      an_n  <= ~(6'b000001 << pos);
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_calc_display_driver.sv
// Scoreboard bench for calc_display_driver: stimulus queues expected results, a monitor checks each commit.
module tb_calc_display_driver;

  localparam int RD = 4;
`ifdef CALC_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  logic        clk  = 1'b0;
  logic        nRST = 1'b1;
  logic [15:0] display_output = 16'h0000;
  logic        complete = 1'b0;
  logic        busy;
  logic [19:0] bcd_out;
  logic        bcd_neg;
  logic        bcd_valid;
  logic [6:0]  seg_n;
  logic [5:0]  an_n;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    int          load_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  logic busy_prev = 1'b0;

  calc_display_driver #(.REFRESH_DIV(RD)) dut (
    .clk            (clk),
    .nRST           (nRST),
    .display_output (display_output),
    .complete       (complete),
    .busy           (busy),
    .bcd_out        (bcd_out),
    .bcd_neg        (bcd_neg),
    .bcd_valid      (bcd_valid),
    .seg_n          (seg_n),
    .an_n           (an_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req)
      passes++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // One-cycle pulse on complete; the expected commit is queued against the load edge.
  task automatic applyStimulus(input logic [15:0] value, input logic [19:0] ebcd, input logic eneg);
    exp_t e;
    @(negedge clk);
    display_output = value;
    complete       = 1'b1;
    e.bcd = ebcd;
    e.neg = eneg;
    e.load_edge = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    complete = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL %s: result timeout, pending %0d, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_pos(input string name, input int p, input logic [6:0] exp_seg);
    int n = 0;
    logic [5:0] want;
    want = ~(6'b000001 << p);
    while (an_n !== want && n < 6*RD + 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_an"}, 32'(an_n), 32'(want));
    checkOutput(name, 32'(seg_n), 32'(exp_seg));
  endtask

  // Monitor: a falling busy outside reset is a commit and must match the oldest queued result.
  always @(negedge clk) begin
    exp_t e;
    if (!nRST) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_commit: got bcd_out %0h, expected no commit", bcd_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
          checkOutput("bcd_neg", 32'(bcd_neg), 32'(e.neg));
          checkOutput("bcd_valid", 32'(bcd_valid), 32'd1);
          checkOutput("latency", 32'(cyc - e.load_edge), 32'd15);
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    nRST = 1'b0;
    complete = 1'b1;
    display_output = 16'h3039;
    #2;
    checkOutput("rst_seg", 32'(seg_n), 32'h7F);
    checkOutput("rst_an", 32'(an_n), 32'h3F);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(bcd_valid), 32'd0);
    @(negedge clk);
    complete = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    checkOutput("first_an", 32'(an_n), 32'h3E);
    bad = 0;
    repeat (6*RD + 2) begin
      @(negedge clk);
      if (seg_n !== 7'h7F) bad++;
    end
    checkOutput("blank_scan", 32'(bad), 32'd0);

    applyStimulus(16'h3039, 20'h12345, 1'b0);
    checkOutput("busy_after_load", 32'(busy), 32'd1);
    wait_result("pos_12345");
    check_pos("p12345_pos0", 0, 7'h12);
    check_pos("p12345_pos4", 4, 7'h79);
    check_pos("p12345_pos5", 5, 7'h7F);

    applyStimulus(16'h800A, 20'h00010, 1'b1);
    wait_result("neg_10");
    check_pos("n10_pos5", 5, 7'h3F);
    check_pos("n10_pos0", 0, 7'h40);
    check_pos("n10_pos1", 1, 7'h79);
    check_pos("n10_pos2", 2, LZ_SEG);
    check_pos("n10_pos4", 4, LZ_SEG);

    applyStimulus(16'h7FFF, 20'h32767, 1'b0);
    wait_result("max_pos");
    check_pos("max_pos4", 4, 7'h30);
    check_pos("max_pos0", 0, 7'h78);

    applyStimulus(16'h8000, 20'h00000, 1'b0);
    wait_result("neg_zero");
    check_pos("nz_pos5", 5, 7'h7F);
    check_pos("nz_pos1", 1, LZ_SEG);
    check_pos("nz_pos0", 0, 7'h40);

    applyStimulus(16'h0000, 20'h00000, 1'b0);
    wait_result("zero");
    check_pos("zero_pos0", 0, 7'h40);

    @(negedge clk);
    display_output = 16'h04D2;
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(16'h8063, 20'h00099, 1'b1);
    wait_result("restart");
    repeat (20) @(negedge clk);
    check_pos("restart_pos5", 5, 7'h3F);

    begin
      exp_t e;
      @(negedge clk);
      display_output = 16'h0007;
      complete = 1'b1;
      e.bcd = 20'h00007;
      e.neg = 1'b0;
      e.load_edge = cyc + 1;
      exp_q.push_back(e);
      repeat (40) @(negedge clk);
      complete = 1'b0;
    end
    wait_result("held");
    repeat (20) @(negedge clk);
    check_pos("held_pos0", 0, 7'h78);

    @(negedge clk);
    display_output = 16'h1111;
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    repeat (6) @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    checkOutput("mid_rst_seg", 32'(seg_n), 32'h7F);
    checkOutput("mid_rst_an", 32'(an_n), 32'h3F);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(bcd_valid), 32'd0);
    checkOutput("mid_rst_bcd", 32'(bcd_out), 32'd0);
    checkOutput("mid_rst_neg", 32'(bcd_neg), 32'd0);
    @(negedge clk);
    #2 nRST = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("no_commit_after_rst", 32'(bcd_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
